// File: rtl/fm_step_engine_if.sv
// Request/response handshake bundle for the FM-index backward-search step engine.
interface fm_step_engine_if #(
    parameter int unsigned SYM_W = 2,
    parameter int unsigned IDX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [SYM_W-1:0] in_sym;
    logic [IDX_W-1:0] in_k;
    logic [IDX_W-1:0] in_l;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_k;
    logic [IDX_W-1:0] out_l;
    logic             out_empty;

    // Requester side: issues steps and consumes results.
    modport master (
        output in_valid, in_sym, in_k, in_l, out_ready,
        input  in_ready, out_valid, out_k, out_l, out_empty
    );

    // Engine side.
    modport slave (
        input  in_valid, in_sym, in_k, in_l, out_ready,
        output in_ready, out_valid, out_k, out_l, out_empty
    );
endinterface

// File: rtl/fm_step_engine.sv
// One FM-index backward-search step: given symbol a and SA interval [k,l], produce
// k' = C(a) + Occ(a,k-1) + 1 and l' = C(a) + Occ(a,l) using external C and Occ ROMs.
module fm_step_engine #(
    parameter int unsigned SYM_W   = 2,
    parameter int unsigned IDX_W   = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned ROM_LAT = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    fm_step_engine_if.slave               bus,
    output logic                          ce_rom_C_o,
    output logic [SYM_W-1:0]              addr_rom_C_o,
    input  logic [CNT_W-1:0]              data_C_i,
    output logic                          ce_rom_Occ_o,
    output logic [IDX_W-1:0]              addr_rom_Occ_o,
    input  logic [(2**SYM_W)*CNT_W-1:0]   data_Occ_i
);
    localparam int unsigned SUM_W = IDX_W + 1;

    typedef enum logic [2:0] {StIdle, StRdC, StRdK, StRdL, StCalc, StOut} state_e;

    state_e           state_q, state_d;
    logic [1:0]       wait_q, wait_d;
    logic [SYM_W-1:0] sym_q, sym_d;
    logic [IDX_W-1:0] k_q, k_d, l_q, l_d;
    logic [CNT_W-1:0] c_q, c_d, occ_k_q, occ_k_d, occ_l_q, occ_l_d;
    logic [IDX_W-1:0] out_k_q, out_k_d, out_l_q, out_l_d;
    logic             out_empty_q, out_empty_d;

    logic             rd_done;
    logic [CNT_W-1:0] occ_sel;
    logic [SUM_W-1:0] k_sum, l_sum;

    // ROM data is only trusted ROM_LAT cycles after the ce cycle of a read state.
    assign rd_done = (wait_q == 2'(ROM_LAT));
    assign occ_sel = data_Occ_i[sym_q*CNT_W +: CNT_W];
    assign k_sum   = SUM_W'(c_q) + SUM_W'(occ_k_q) + SUM_W'(1);
    assign l_sum   = SUM_W'(c_q) + SUM_W'(occ_l_q);

    assign bus.out_k     = out_k_q;
    assign bus.out_l     = out_l_q;
    assign bus.out_empty = out_empty_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wait_q      <= '0;
            sym_q       <= '0;
            k_q         <= '0;
            l_q         <= '0;
            c_q         <= '0;
            occ_k_q     <= '0;
            occ_l_q     <= '0;
            out_k_q     <= '0;
            out_l_q     <= '0;
            out_empty_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            sym_q       <= sym_d;
            k_q         <= k_d;
            l_q         <= l_d;
            c_q         <= c_d;
            occ_k_q     <= occ_k_d;
            occ_l_q     <= occ_l_d;
            out_k_q     <= out_k_d;
            out_l_q     <= out_l_d;
            out_empty_q <= out_empty_d;
        end
    end

    // Next-state, ROM sequencing and handshake outputs.
    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        sym_d          = sym_q;
        k_d            = k_q;
        l_d            = l_q;
        c_d            = c_q;
        occ_k_d        = occ_k_q;
        occ_l_d        = occ_l_q;
        out_k_d        = out_k_q;
        out_l_d        = out_l_q;
        out_empty_d    = out_empty_q;
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        ce_rom_C_o     = 1'b0;
        addr_rom_C_o   = '0;
        ce_rom_Occ_o   = 1'b0;
        addr_rom_Occ_o = '0;

        unique case (state_q)
            StIdle: begin
                bus.in_ready = !rst;
                if (bus.in_valid && bus.in_ready) begin
                    sym_d  = bus.in_sym;
                    k_d    = bus.in_k;
                    l_d    = bus.in_l;
                    wait_d = '0;
                    if (bus.in_k > bus.in_l) begin
                        // Already-empty interval passes straight through without ROM reads.
                        out_k_d     = bus.in_k;
                        out_l_d     = bus.in_l;
                        out_empty_d = 1'b1;
                        state_d     = StOut;
                    end else begin
                        state_d = StRdC;
                    end
                end
            end
            StRdC: begin
                ce_rom_C_o   = (wait_q == 2'd0);
                addr_rom_C_o = sym_q;
                if (rd_done) begin
                    c_d    = data_C_i;
                    wait_d = '0;
                    if (k_q == '0) begin
                        // Occ(a,-1) is defined as zero, so the k read is skipped.
                        occ_k_d = '0;
                        state_d = StRdL;
                    end else begin
                        state_d = StRdK;
                    end
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            StRdK: begin
                ce_rom_Occ_o   = (wait_q == 2'd0);
                addr_rom_Occ_o = k_q - IDX_W'(1);
                if (rd_done) begin
                    occ_k_d = occ_sel;
                    wait_d  = '0;
                    state_d = StRdL;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            StRdL: begin
                ce_rom_Occ_o   = (wait_q == 2'd0);
                addr_rom_Occ_o = l_q;
                if (rd_done) begin
                    occ_l_d = occ_sel;
                    wait_d  = '0;
                    state_d = StCalc;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            StCalc: begin
                // Emptiness uses the full-width sums; outputs keep the low bits.
                out_k_d     = k_sum[IDX_W-1:0];
                out_l_d     = l_sum[IDX_W-1:0];
                out_empty_d = (k_sum > l_sum);
                state_d     = StOut;
            end
            StOut: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end
endmodule

// File: doc/fm_step_engine.md
FM_STEP_ENGINE -- requirements
Module: fm_step_engine

Parameters
REQ-001 The block SHALL have parameter SYM_W, default 2, meaning the symbol width; the alphabet size is A = 2^SYM_W.
REQ-002 The block SHALL have parameter IDX_W, default 8, meaning the BWT index width for k, l and the Occ ROM address.
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning the width of each C entry and each per-symbol Occ count.
REQ-004 The block SHALL have parameter ROM_LAT, default 0, legal range 0..2, meaning the ROM read latency in cycles after the ce cycle (0 means combinational).

Interface
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  the single clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 in_valid  in  1  a step request is present.
REQ-009 in_ready  out  1  the engine accepts a request this cycle.
REQ-010 in_sym  in  SYM_W  the symbol a to prepend.
REQ-011 in_k, in_l  in  IDX_W each  the current SA interval [k,l], inclusive at both ends.
REQ-012 out_valid  out  1  a result is present.
REQ-013 out_ready  in  1  the consumer accepts the result.
REQ-014 out_k, out_l  out  IDX_W each  the new interval.
REQ-015 out_empty  out  1  the new interval is empty.
REQ-016 ce_rom_C_o  out  1  C ROM read enable.
REQ-017 addr_rom_C_o  out  SYM_W  C ROM address.
REQ-018 data_C_i  in  CNT_W  C ROM data.
REQ-019 ce_rom_Occ_o  out  1  Occ ROM read enable.
REQ-020 addr_rom_Occ_o  out  IDX_W  Occ ROM address.
REQ-021 data_Occ_i  in  A*CNT_W  Occ ROM data; the count for symbol s is at bits [s*CNT_W +: CNT_W].

Function
REQ-022 The block SHALL compute one backward-search step: k' = C(a) + Occ(a,k-1) + 1 and l' = C(a) + Occ(a,l).
REQ-023 The FSM SHALL have the states IDLE, RD_C, RD_K, RD_L, CALC and OUT.
REQ-024 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid && in_ready, and in_sym, in_k and in_l are latched at that edge.
REQ-025 On acceptance with in_k <= in_l, the FSM SHALL go to RD_C; with in_k > in_l it SHALL go directly to OUT with out_empty=1 and out_k/out_l equal to the inputs, issuing no ROM reads.
REQ-026 In each RD state, ce SHALL be high for exactly the first cycle with the address stable; the address SHALL be held for ROM_LAT further cycles; data SHALL be sampled in the cycle ce + ROM_LAT.
REQ-027 Addresses SHALL be: RD_C uses a; RD_K uses k-1; RD_L uses l.
REQ-028 RD_K SHALL be skipped when k == 0, with Occ(a,-1) taken as 0.
REQ-029 At most one ce SHALL be high in any cycle.
REQ-030 Sequencing SHALL be RD_C -> RD_K (or RD_L if k == 0) -> RD_L -> CALC (1 cycle) -> OUT.
REQ-031 CALC SHALL compute in IDX_W+1 bits with operands zero-extended.
REQ-032 out_empty SHALL be set to (k' > l') at full width; out_k and out_l SHALL carry the low IDX_W bits.
REQ-033 In OUT, out_valid=1 and the outputs SHALL be held stable until out_ready; on out_valid && out_ready the FSM SHALL return to IDLE.
REQ-034 Latency from the accepting edge to the first out_valid cycle SHALL be 5+3*ROM_LAT cycles for k > 0, 4+2*ROM_LAT for k == 0, and 1 for an empty input.
REQ-035 Throughput SHALL be one request in flight; no new request is accepted while out_valid is pending.
REQ-036 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-037 While rst=1: FSM=IDLE, out_valid=0, out_k=0, out_l=0, out_empty=0, both ce=0, both addresses=0, and in_ready=0.
REQ-038 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-039 A reset asserted mid-operation SHALL abandon the step with no output produced, and the next request after reset SHALL compute correctly.

Verification
ROM image for all scenarios: C = {0,3,5,8}; Occ row 4 sym1 = 2; row 6 sym1 = 3; row 0 sym2 = 0.
REQ-040 ROM_LAT=0, a=1, k=5, l=6 -> out (6,6), out_empty=0, out_valid 5 cycles after accept; ce pulses in the order C, Occ@4, Occ@6.
REQ-041 ROM_LAT=2, same request -> same result at 11 cycles; each address held for 3 cycles; ce high for 1 cycle each.
REQ-042 a=2, k=0, l=0 -> no Occ read at index -1; Occ@0 read once; out (6,5), out_empty=1, 4 cycles after accept.
REQ-043 k=7, l=3 -> out_empty=1, out (7,3), no ce ever asserted, out_valid 1 cycle after accept.
REQ-044 out_ready held low for 10 cycles -> outputs stable and in_ready=0 throughout; returns to IDLE the cycle after the handshake.
REQ-045 rst asserted during RD_L -> all outputs at reset values the next cycle; a following request gives the correct result.
